// File: rtl/ir_fetch_unit.sv
// Instruction fetch + instruction register: one-word read at PC, latch into IR, decode fields.
// Latency: MemRead/MemAddr one edge after FetchStart; IR/fields one edge after MemReady (zero with IR_BYPASS_EN).
// Backpressure: FetchStart accepted only in IDLE; WAIT holds the request until MemReady or timeout.
//
// Optional feature macro: IR_BYPASS_EN -- when defined, Instr and the decoded fields
// follow MemData combinationally in the WAIT cycle where MemReady is high.
//
// Ports:
//   clk, reset_n            clock (rising edge) and asynchronous active-low reset
//   FetchStart, PC          fetch request and address (sampled in IDLE only)
//   MemAddr, MemRead        registered read address and strobe to memory
//   MemReady, MemData       memory data valid and read data
//   Busy, IRValid, FetchErr status: waiting, IR freshly fetched, one-cycle error pulse
//   Instr and fields        IR contents and its Opcode/Rs/Rt/Rd/Shamt/Funct/Imm16/JTarget slices
module ir_fetch_unit #(
   parameter int          TIMEOUT_CYCLES = 16,          // legal range 2..255
   parameter logic [31:0] RESET_INSTR    = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        FetchStart,
   input  logic [31:0] PC,
   output logic [31:0] MemAddr,
   output logic        MemRead,
   input  logic        MemReady,
   input  logic [31:0] MemData,
   output logic        Busy,
   output logic        IRValid,
   output logic        FetchErr,
   output logic [31:0] Instr,
   output logic [5:0]  Opcode,
   output logic [4:0]  Rs,
   output logic [4:0]  Rt,
   output logic [4:0]  Rd,
   output logic [4:0]  Shamt,
   output logic [5:0]  Funct,
   output logic [15:0] Imm16,
   output logic [25:0] JTarget
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   // Counter value of the last WAIT cycle before the request is abandoned.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   logic [31:0] mem_addr_q;
   logic        mem_read_q;
   logic        busy_q;
   logic        ir_valid_q;
   logic        fetch_err_q;
   logic [31:0] instr_q;
   logic [7:0]  cnt_q;
   logic [31:0] instr_out;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         mem_addr_q  <= 32'h0;
         mem_read_q  <= 1'b0;
         busy_q      <= 1'b0;
         ir_valid_q  <= 1'b0;
         fetch_err_q <= 1'b0;
         instr_q     <= RESET_INSTR;
         cnt_q       <= 8'h0;
      end else begin
         // Error is a single-cycle pulse; only the cases below re-raise it.
         fetch_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (FetchStart) begin
                  ir_valid_q <= 1'b0;
                  if (PC[1:0] == 2'b00) begin
                     mem_addr_q <= PC;
                     mem_read_q <= 1'b1;
                     busy_q     <= 1'b1;
                     cnt_q      <= 8'h0;
                     state_q    <= S_WAIT;
                  end else begin
                     // Misaligned: reject without touching memory.
                     fetch_err_q <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               // MemReady wins over the timeout on the final count cycle.
               if (MemReady) begin
                  instr_q    <= MemData;
                  ir_valid_q <= 1'b1;
                  mem_read_q <= 1'b0;
                  busy_q     <= 1'b0;
                  state_q    <= S_IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  mem_read_q  <= 1'b0;
                  busy_q      <= 1'b0;
                  fetch_err_q <= 1'b1;
                  state_q     <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef IR_BYPASS_EN
   // Forward the arriving word in its MemReady cycle; the IR takes over from the next cycle.
   always_comb begin
      instr_out = instr_q;
      if (state_q == S_WAIT && MemReady) instr_out = MemData;
   end
`else
   always_comb begin
      instr_out = instr_q;
   end
`endif

   assign MemAddr  = mem_addr_q;
   assign MemRead  = mem_read_q;
   assign Busy     = busy_q;
   assign IRValid  = ir_valid_q;
   assign FetchErr = fetch_err_q;
   assign Instr    = instr_out;
   assign Opcode   = instr_out[31:26];
   assign Rs       = instr_out[25:21];
   assign Rt       = instr_out[20:16];
   assign Rd       = instr_out[15:11];
   assign Shamt    = instr_out[10:6];
   assign Funct    = instr_out[5:0];
   assign Imm16    = instr_out[15:0];
   assign JTarget  = instr_out[25:0];

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Self-checking bench for ir_fetch_unit: directed scenarios plus randomized traffic,
// checked every cycle against a request-level model and pinned by literal expectations.
// Runs with TIMEOUT_CYCLES=4.
module tb_ir_fetch_unit;
   localparam int T = 4;

   logic        clk;
   logic        reset_n;
   logic        FetchStart;
   logic [31:0] PC;
   logic [31:0] MemAddr;
   logic        MemRead;
   logic        MemReady;
   logic [31:0] MemData;
   logic        Busy;
   logic        IRValid;
   logic        FetchErr;
   logic [31:0] Instr;
   logic [5:0]  Opcode;
   logic [4:0]  Rs;
   logic [4:0]  Rt;
   logic [4:0]  Rd;
   logic [4:0]  Shamt;
   logic [5:0]  Funct;
   logic [15:0] Imm16;
   logic [25:0] JTarget;

   int n_cmp  = 0;
   int n_bad  = 0;
   int rd_run = 0;
   int last_burst = 0;

   ir_fetch_unit #(.TIMEOUT_CYCLES(T), .RESET_INSTR(32'h00000000)) dut (
      .clk(clk), .reset_n(reset_n), .FetchStart(FetchStart), .PC(PC),
      .MemAddr(MemAddr), .MemRead(MemRead), .MemReady(MemReady), .MemData(MemData),
      .Busy(Busy), .IRValid(IRValid), .FetchErr(FetchErr), .Instr(Instr),
      .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Funct(Funct),
      .Imm16(Imm16), .JTarget(JTarget)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Request-level model: an outstanding read with its age in WAIT cycles (1-based).
   logic        m_out;
   logic [31:0] m_addr;
   logic [31:0] m_ir;
   logic        m_valid;
   logic        m_err;
   int          m_age;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_out <= 1'b0; m_addr <= 32'h0; m_ir <= 32'h0;
         m_valid <= 1'b0; m_err <= 1'b0; m_age <= 0;
      end else begin
         m_err <= 1'b0;
         if (!m_out) begin
            if (FetchStart) begin
               m_valid <= 1'b0;
               if (PC[1:0] == 2'b00) begin
                  m_out <= 1'b1; m_addr <= PC; m_age <= 1;
               end else begin
                  m_err <= 1'b1;
               end
            end
         end else if (MemReady) begin
            m_ir <= MemData; m_valid <= 1'b1; m_out <= 1'b0;
         end else if (m_age == T) begin
            m_out <= 1'b0; m_err <= 1'b1;
         end else begin
            m_age <= m_age + 1;
         end
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      logic [31:0] e_instr;
      if (reset_n) begin
         e_instr = m_ir;
`ifdef IR_BYPASS_EN
         if (m_out && MemReady) e_instr = MemData;
`endif
         chk("MemRead",  {31'h0, MemRead},  {31'h0, m_out});
         chk("MemAddr",  MemAddr,           m_addr);
         chk("Busy",     {31'h0, Busy},     {31'h0, m_out});
         chk("IRValid",  {31'h0, IRValid},  {31'h0, m_valid});
         chk("FetchErr", {31'h0, FetchErr}, {31'h0, m_err});
         chk("Instr",    Instr,             e_instr);
         chk("fields",   {Opcode, Rs, Rt, Rd, Shamt, Funct}, e_instr);
         chk("Imm16",    {16'h0, Imm16},    {16'h0, e_instr[15:0]});
         chk("JTarget",  {6'h0, JTarget},   {6'h0, e_instr[25:0]});
      end
   end

   // Advance one cycle; inputs set before the call apply at this edge.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (MemRead) rd_run++;
      else if (rd_run > 0) begin
         last_burst = rd_run;
         rd_run = 0;
         chk("rd_burst_max", {31'h0, last_burst <= T}, 32'h1);
      end
   endtask

   initial begin
      logic [31:0] pc;
      reset_n = 1'b0; FetchStart = 1'b0; PC = 32'h0; MemReady = 1'b0; MemData = 32'h0;
      #12;
      chk("rst_MemRead",  {31'h0, MemRead},  32'h0);
      chk("rst_MemAddr",  MemAddr,           32'h0);
      chk("rst_Busy",     {31'h0, Busy},     32'h0);
      chk("rst_IRValid",  {31'h0, IRValid},  32'h0);
      chk("rst_FetchErr", {31'h0, FetchErr}, 32'h0);
      chk("rst_Instr",    Instr,             32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Basic fetch, ready on WAIT cycle 3.
      FetchStart = 1'b1; PC = 32'h00400000;
      cyc();
      FetchStart = 1'b0;
      chk("basic_MemAddr", MemAddr, 32'h00400000);
      chk("basic_MemRead", {31'h0, MemRead}, 32'h1);
      cyc();
      cyc();
      MemReady = 1'b1; MemData = 32'h2008FFFC;
      cyc();
      MemReady = 1'b0;
      chk("basic_burst",   last_burst,        32'd3);
      chk("basic_Opcode",  {26'h0, Opcode},   32'h08);
      chk("basic_Rs",      {27'h0, Rs},       32'h0);
      chk("basic_Rt",      {27'h0, Rt},       32'h8);
      chk("basic_Imm16",   {16'h0, Imm16},    32'hFFFC);
      chk("basic_IRValid", {31'h0, IRValid},  32'h1);

      // Load IR with 0x012A4020 (back-to-back with the previous completion), then time out.
      FetchStart = 1'b1; PC = 32'h00400004;
      cyc();
      FetchStart = 1'b0; MemReady = 1'b1; MemData = 32'h012A4020;
      cyc();
      MemReady = 1'b0;
      chk("load_Instr", Instr, 32'h012A4020);
      FetchStart = 1'b1; PC = 32'h00400008;
      cyc();
      FetchStart = 1'b0;
      for (int i = 0; i < T; i++) cyc();
      chk("to_burst",    last_burst,        T);
      chk("to_FetchErr", {31'h0, FetchErr}, 32'h1);
      chk("to_Instr",    Instr,             32'h012A4020);
      chk("to_IRValid",  {31'h0, IRValid},  32'h0);
      cyc();
      chk("to_FetchErr_end", {31'h0, FetchErr}, 32'h0);

      // Misaligned PC.
      FetchStart = 1'b1; PC = 32'h00400002;
      cyc();
      FetchStart = 1'b0;
      chk("mis_FetchErr", {31'h0, FetchErr}, 32'h1);
      chk("mis_MemRead",  {31'h0, MemRead},  32'h0);
      chk("mis_Busy",     {31'h0, Busy},     32'h0);
      cyc();
      chk("mis_FetchErr_end", {31'h0, FetchErr}, 32'h0);

      // FetchStart ignored during WAIT.
      FetchStart = 1'b1; PC = 32'h00400000;
      cyc();
      PC = 32'h00400004;
      cyc();
      FetchStart = 1'b0;
      chk("ign_MemAddr", MemAddr, 32'h00400000);
      MemReady = 1'b1; MemData = 32'h08100003;
      cyc();
      MemReady = 1'b0;
      chk("ign_burst",   last_burst,       32'd2);
      chk("ign_JTarget", {6'h0, JTarget},  32'h0100003);
      cyc();
      chk("ign_no_req",  {31'h0, MemRead}, 32'h0);

      // Reset during WAIT cycle 1, then a normal fetch.
      FetchStart = 1'b1; PC = 32'h00400020;
      cyc();
      FetchStart = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("rmw_MemRead",  {31'h0, MemRead},  32'h0);
      chk("rmw_Busy",     {31'h0, Busy},     32'h0);
      chk("rmw_Instr",    Instr,             32'h0);
      chk("rmw_FetchErr", {31'h0, FetchErr}, 32'h0);
      rd_run = 0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      cyc();
      chk("rmw_FetchErr_after", {31'h0, FetchErr}, 32'h0);
      FetchStart = 1'b1; PC = 32'h00400010;
      cyc();
      FetchStart = 1'b0; MemReady = 1'b1; MemData = 32'h12345678;
      cyc();
      MemReady = 1'b0;
      chk("rmw_refetch_Instr",   Instr,            32'h12345678);
      chk("rmw_refetch_IRValid", {31'h0, IRValid}, 32'h1);

      // MemReady on the final count cycle is a success.
      FetchStart = 1'b1; PC = 32'h00400040;
      cyc();
      FetchStart = 1'b0;
      for (int i = 1; i < T; i++) cyc();
      MemReady = 1'b1; MemData = 32'h8FA80010;
`ifdef IR_BYPASS_EN
      #1;
      chk("bnd_bypass_Opcode", {26'h0, Opcode}, 32'h23);
`endif
      cyc();
      MemReady = 1'b0;
      chk("bnd_burst",    last_burst,        T);
      chk("bnd_IRValid",  {31'h0, IRValid},  32'h1);
      chk("bnd_Imm16",    {16'h0, Imm16},    32'h0010);
      chk("bnd_Opcode",   {26'h0, Opcode},   32'h23);
      chk("bnd_FetchErr", {31'h0, FetchErr}, 32'h0);

      // Randomized traffic, checked by the per-cycle compare.
      for (int i = 0; i < 3000; i++) begin
         pc = $urandom;
         if ($urandom_range(0, 4) != 0) pc[1:0] = 2'b00;
         FetchStart = ($urandom_range(0, 2) == 0);
         PC         = pc;
         MemReady   = ($urandom_range(0, 3) == 0);
         MemData    = $urandom;
         cyc();
      end
      FetchStart = 1'b0; MemReady = 1'b0;
      cyc();
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ir_fetch_unit.md
Name: ir_fetch_unit

Overview:
- Instruction fetch and instruction-register stage of the multicycle CPU.
- Issues a single-word memory read at PC when the control FSM requests a fetch, waits for memory, and latches the word into the IR.
- Presents decoded instruction fields. Imm16 feeds the sign-extension stage directly downstream; the other fields feed the register file and control.
- Reports misaligned-PC and memory-timeout errors.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles MemRead stays asserted without MemReady before abort; legal range 2..255.
- RESET_INSTR, 32'h00000000, IR value after reset (MIPS nop).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- FetchStart  input  1  fetch request from control FSM, sampled in IDLE only.
- PC  input  32  fetch address, sampled with FetchStart.
- MemAddr  output  32  registered read address.
- MemRead  output  1  registered read strobe.
- MemReady  input  1  memory data valid this cycle.
- MemData  input  32  memory read data.
- Busy  output  1  high in WAIT.
- IRValid  output  1  IR holds a freshly fetched word.
- FetchErr  output  1  one-cycle error pulse.
- Instr  output  32  IR contents.
- Opcode  output  6  Instr[31:26].
- Rs  output  5  Instr[25:21].
- Rt  output  5  Instr[20:16].
- Rd  output  5  Instr[15:11].
- Shamt  output  5  Instr[10:6].
- Funct  output  6  Instr[5:0].
- Imm16  output  16  Instr[15:0], to sign-extension stage.
- JTarget  output  26  Instr[25:0].

Behaviour:
- Reset (asynchronous, any state):
  - State=IDLE.
  - MemRead=0, MemAddr=0, Busy=0, IRValid=0, FetchErr=0.
  - Instr=RESET_INSTR; wait counter=0.
- Field outputs are pure slices of the IR register: valid the cycle after the IR updates.
- IDLE:
  - FetchStart=1 with PC[1:0]==0: next edge MemAddr<=PC, MemRead<=1, Busy<=1, IRValid<=0, counter<=0, go WAIT.
  - FetchStart=1 with PC[1:0]!=0: no memory request; FetchErr=1 for one cycle starting next edge; IRValid<=0; stay IDLE.
- WAIT:
  - MemRead and MemAddr held constant. FetchStart is ignored.
  - MemReady=1: Instr<=MemData, IRValid<=1, MemRead<=0, Busy<=0, go IDLE. Data latency is one cycle after the MemReady cycle.
  - MemReady=0 with counter==TIMEOUT_CYCLES-1: MemRead<=0, Busy<=0, FetchErr pulses 1 cycle, Instr unchanged, IRValid stays 0, go IDLE.
  - Otherwise: counter increments.
  - MemRead is high for at most TIMEOUT_CYCLES cycles.
  - MemReady on the final count cycle counts as success; no error is raised.
- IRValid stays high until the next accepted or rejected FetchStart clears it.
- Back-to-back operation: FetchStart in the same cycle IRValid rises is accepted. Minimum fetch-to-fetch spacing is 2 cycles plus wait states.
- MemReady in IDLE is ignored; the IR is unchanged.
- Reset asserted mid-WAIT aborts immediately. No FetchErr; IR returns to RESET_INSTR.

Optional Feature:
- Macro IR_BYPASS_EN.
- Defined: in the WAIT cycle with MemReady=1, Instr and all field outputs are driven combinationally from MemData (zero-latency bypass). The IR is still written at that edge, so values are continuous afterwards. IRValid timing is unchanged.
- Undefined: outputs always come from the IR register only.

Test Plan:
- Basic fetch: PC=0x00400000, FetchStart 1 cycle, MemReady high on the 3rd WAIT cycle with MemData=0x2008FFFC. Required: MemRead high 3 cycles, MemAddr=0x00400000; next cycle Opcode=0x08, Rs=0, Rt=8, Imm16=0xFFFC, IRValid=1.
- Timeout: TIMEOUT_CYCLES=4, MemReady never asserted, IR previously 0x012A4020. Required: MemRead high exactly 4 cycles, FetchErr 1-cycle pulse, Instr still 0x012A4020, IRValid=0.
- Misaligned PC: PC=0x00400002 with FetchStart. Required: MemRead never asserted, FetchErr pulse next cycle, Busy=0.
- Ignore during WAIT: second FetchStart with PC=0x00400004 during WAIT, MemReady on WAIT cycle 2 with MemData=0x08100003. Required: MemAddr stays 0x00400000, JTarget=0x0100003, no second request.
- Reset mid-WAIT: reset_n low on WAIT cycle 1. Required: MemRead=0 and Busy=0 asynchronously, Instr=0x00000000, no FetchErr. A subsequent fetch works normally.
- Boundary: MemReady on the last count cycle (TIMEOUT_CYCLES=4, ready on WAIT cycle 4, MemData=0x8FA80010). Required: success, IRValid=1, Imm16=0x0010, FetchErr=0. Under IR_BYPASS_EN, Opcode=0x23 is visible in the MemReady cycle itself.
